// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - parametrised UART transmitter with input FIFO and CTS gating
//
// Purpose:
//   Serialises words from a small FIFO onto txd.
//   Frame format: start bit, DATA_BITS data bits sent LSB first, an optional
//   even or odd parity bit, then STOP_BITS stop bits.
//   A new frame starts only while the synchronised cts_n is low. Consecutive
//   frames go out back-to-back, with no idle cycle between them.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   s_data     in   word to transmit (DATA_BITS wide)
//   s_valid    in   s_data valid
//   s_ready    out  FIFO not full; a push happens when s_valid && s_ready
//   cts_n      in   clear-to-send, active low, asynchronous to clk
//   txd        out  serial line, idle high
//   busy       out  a frame is on the line
//   fifo_count out  number of words held in the FIFO

module uart_tx_fifo_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          cts_n,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [0:0]    STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_PAR  = (PARITY == 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  // Transmitter state
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [0:0]           r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic [1:0]           r_cts_sync;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_cts_ok;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_par_load;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign s_ready    = !w_full;
  assign w_push     = s_valid && s_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_cts_ok   = !r_cts_sync[1];
  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_last_stop = (r_state == S_STOP) && w_tick && (r_stop_idx == STOP_LAST);
  // A frame starts from IDLE, or directly from the end of the last stop bit
  // so that queued words leave without an idle gap.
  assign w_pop      = !w_empty && w_cts_ok && ((r_state == S_IDLE) || w_last_stop);
  // The parity bit is computed once, from the word as it is loaded.
  assign w_par_load = (^w_head) ^ ODD_PAR;

  assign txd        = r_txd;
  assign busy       = (r_state != S_IDLE);
  assign fifo_count = r_count;

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Two-flop synchroniser. It resets to "not clear", so the line must be seen
  // low for two clocks after reset before a frame may start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cts_sync <= 2'b11;
    end else begin
      r_cts_sync <= {r_cts_sync[0], cts_n};
    end
  end

  // The baud counter is held at zero in IDLE, so entering START always begins
  // a full bit period. Every other bit boundary wraps it back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= '0;
      r_stop_idx <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= w_par_load;
            r_state <= S_START;
            r_txd   <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == BIT_LAST) begin
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_txd   <= r_par;
              end else begin
                r_state    <= S_STOP;
                r_stop_idx <= '0;
                r_txd      <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_state    <= S_STOP;
            r_stop_idx <= '0;
            r_txd      <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_stop_idx == STOP_LAST) begin
              if (w_pop) begin
                r_shift <= w_head;
                r_par   <= w_par_load;
                r_state <= S_START;
                r_txd   <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_txd   <= 1'b1;
              end
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - directed self-checking bench for uart_tx_fifo_param

module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic [7:0] s_data_a;
  logic       s_valid_a;
  logic       s_ready_a;
  logic       cts_n_a;
  logic       txd_a;
  logic       busy_a;
  logic [2:0] count_a;

  logic [6:0] s_data_p;
  logic       s_valid_p;
  logic       cts_n_p;
  logic       s_ready_o, txd_o, busy_o;
  logic [2:0] count_o;
  logic       s_ready_e, txd_e, busy_e;
  logic [2:0] count_e;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] v_a, v_o, v_e;

  logic [9:0] exp_bt [4] = '{10'h202, 10'h204, 10'h206, 10'h208};
  logic [9:0] exp_sp [3] = '{10'h2D6, 10'h2F8, 10'h31A};
  logic [2:0] cnt_sp [3] = '{3'd2, 3'd1, 3'd0};

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .cts_n(cts_n_a), .txd(txd_a), .busy(busy_a),
    .fifo_count(count_a)
  );

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_o (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_p), .s_valid(s_valid_p),
    .s_ready(s_ready_o), .cts_n(cts_n_p), .txd(txd_o), .busy(busy_o),
    .fifo_count(count_o)
  );

  uart_tx_fifo_param #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_e (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_p), .s_valid(s_valid_p),
    .s_ready(s_ready_e), .cts_n(cts_n_p), .txd(txd_e), .busy(busy_e),
    .fifo_count(count_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    s_data_a  = d;
    s_valid_a = 1'b1;
    @(posedge clk);
    #1;
    s_valid_a = 1'b0;
  endtask

  task automatic push_p(input logic [6:0] d);
    @(negedge clk);
    s_data_p  = d;
    s_valid_p = 1'b1;
    @(posedge clk);
    #1;
    s_valid_p = 1'b0;
  endtask

  task automatic sample_bits(input int n);
    v_a = '0;
    v_o = '0;
    v_e = '0;
    step(5);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step(10);
      v_a[i] = txd_a;
      v_o[i] = txd_o;
      v_e[i] = txd_e;
    end
    step(4);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    s_data_a  = '0;
    s_valid_a = 1'b0;
    cts_n_a   = 1'b0;
    s_data_p  = '0;
    s_valid_p = 1'b0;
    cts_n_p   = 1'b0;

    step(3);
    check("rst_txd", txd_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ready", s_ready_a, 1);
    check("rst_txd_o", txd_o, 1);
    check("rst_count_o", count_o, 0);
    check("rst_ready_o", s_ready_o, 1);
    check("rst_count_e", count_e, 0);
    check("rst_ready_e", s_ready_e, 1);

    @(negedge clk);
    rst_n = 1'b1;
    step(3);

    push_a(8'hA5);
    check("t1_pre", txd_a, 1);
    step(1);
    check("t1_start", txd_a, 0);
    check("t1_busy_on", busy_a, 1);
    check("t1_count", count_a, 0);
    sample_bits(10);
    check("t1_bits", v_a[9:0], 10'h34A);
    check("t1_busy_99", busy_a, 1);
    step(1);
    check("t1_busy_100", busy_a, 0);
    check("t1_idle_txd", txd_a, 1);

    push_p(7'h41);
    step(1);
    check("t2_start_o", txd_o, 0);
    check("t2_start_e", txd_e, 0);
    sample_bits(11);
    check("t2_bits_odd", v_o[10:0], 11'h782);
    check("t2_bits_even", v_e[10:0], 11'h682);
    check("t2_busy_109", busy_o, 1);
    step(1);
    check("t2_busy_110_o", busy_o, 0);
    check("t2_busy_110_e", busy_e, 0);

    @(negedge clk);
    cts_n_a = 1'b1;
    step(3);
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    push_a(8'h04);
    check("t3_full_count", count_a, 4);
    check("t3_full_ready", s_ready_a, 0);
    check("t3_held_busy", busy_a, 0);
    push_a(8'h05);
    check("t3_no_overflow", count_a, 4);
    @(negedge clk);
    cts_n_a = 1'b0;
    step(2);
    check("t3_cts_lat", txd_a, 1);
    step(1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_start_%0d", k), txd_a, 0);
      check($sformatf("t3_count_%0d", k), count_a, 32'(3 - k));
      sample_bits(10);
      check($sformatf("t3_bits_%0d", k), v_a[9:0], exp_bt[k]);
      check($sformatf("t3_busy_%0d", k), busy_a, 1);
      step(1);
    end
    check("t3_end_busy", busy_a, 0);
    check("t3_end_txd", txd_a, 1);
    check("t3_end_count", count_a, 0);

    push_a(8'h11);
    push_a(8'h22);
    check("t4_count", count_a, 1);
    check("t4_start", txd_a, 0);
    step(30);
    @(negedge clk);
    cts_n_a = 1'b1;
    step(69);
    check("t4_stop_txd", txd_a, 1);
    check("t4_not_trunc", busy_a, 1);
    step(1);
    check("t4_idle", busy_a, 0);
    check("t4_hold_count", count_a, 1);
    step(10);
    check("t4_held", busy_a, 0);
    @(negedge clk);
    cts_n_a = 1'b0;
    step(2);
    check("t4_cts_2cyc", txd_a, 1);
    step(1);
    check("t4_restart", txd_a, 0);
    check("t4_restart_count", count_a, 0);
    sample_bits(10);
    check("t4_bits", v_a[9:0], 10'h244);
    step(1);
    check("t4_end_busy", busy_a, 0);

    push_a(8'h5A);
    push_a(8'h6B);
    push_a(8'h7C);
    check("t5_pre_count", count_a, 2);
    step(98);
    push_a(8'h8D);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_start_%0d", k), txd_a, 0);
      check($sformatf("t5_count_%0d", k), count_a, cnt_sp[k]);
      sample_bits(10);
      check($sformatf("t5_bits_%0d", k), v_a[9:0], exp_sp[k]);
      step(1);
    end
    check("t5_end_busy", busy_a, 0);

    push_a(8'h00);
    push_a(8'h00);
    check("t6_count", count_a, 1);
    step(44);
    check("t6_pre_txd", txd_a, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_txd", txd_a, 1);
    check("t6_rst_count", count_a, 0);
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_ready", s_ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("t6_after_busy", busy_a, 0);
    push_a(8'h3C);
    check("t6_pre", txd_a, 1);
    step(1);
    check("t6_start", txd_a, 0);
    sample_bits(10);
    check("t6_bits", v_a[9:0], 10'h278);
    step(1);
    check("t6_end_busy", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
